// File: rtl/reg_ctrl_pkg.sv
// Shared encodings for the selectable-operation register and its command sequencer.
package reg_ctrl_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned CNT_W_DEF  = 5;

   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_CPL  = 2'd1,
      OP_SHR  = 2'd2,
      OP_SHL  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/reg_op_sequencer_if.sv
// Host-side command handshake and status bundle for reg_op_sequencer.
interface reg_op_sequencer_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 5
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [CNT_W-1:0]  cmd_count;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_rotate;
   logic              abort;
   logic              busy;
   logic              done;
   logic              aborted;

   modport master (
      output cmd_valid, cmd_op, cmd_count, cmd_data, cmd_rotate, abort,
      input  cmd_ready, busy, done, aborted
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_count, cmd_data, cmd_rotate, abort,
      output cmd_ready, busy, done, aborted
   );
endinterface

// File: rtl/reg_op_sequencer.sv
// Runs one register operation for cmd_count cycles per accepted command,
// feeding serial data or rotate feedback, then pulses done.
module reg_op_sequencer
   import reg_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned CNT_W  = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   reg_op_sequencer_if.slave   cmd,
   input  logic [3:0]          q_in,
   output logic [1:0]          s,
   output logic                shift_in_R,
   output logic                shift_in_L
);

   state_e            r_state;
   op_e               r_op;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_data;
   logic              r_rot;
   logic              r_aborted;

   state_e            w_state_nxt;
   op_e               w_op_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_rot_nxt;
   logic              w_aborted_nxt;
   logic [CNT_W-1:0]  w_cnt_sat;
   logic              w_accept;
   logic              w_unused_q_mid;

   // Only q[3] and q[0] are needed for rotate feedback.
   assign w_unused_q_mid = ^q_in[2:1];

   assign w_cnt_sat = (cmd.cmd_count > CNT_W'(DATA_W)) ? CNT_W'(DATA_W) : cmd.cmd_count;
   assign w_accept  = (r_state == IDLE) && cmd.cmd_valid && !cmd.abort && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= OP_HOLD;
         r_cnt     <= '0;
         r_data    <= '0;
         r_rot     <= 1'b0;
         r_aborted <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_op      <= w_op_nxt;
         r_cnt     <= w_cnt_nxt;
         r_data    <= w_data_nxt;
         r_rot     <= w_rot_nxt;
         r_aborted <= w_aborted_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_op_nxt      = r_op;
      w_cnt_nxt     = r_cnt;
      w_data_nxt    = r_data;
      w_rot_nxt     = r_rot;
      w_aborted_nxt = r_aborted;
      s             = OP_HOLD;
      shift_in_R    = 1'b0;
      shift_in_L    = 1'b0;
      cmd.cmd_ready = 1'b0;
      cmd.busy      = 1'b0;
      cmd.done      = 1'b0;
      cmd.aborted   = 1'b0;

      case (r_state)
         IDLE: begin
            cmd.cmd_ready = !cmd.abort && !reset;
            if (w_accept) begin
               w_op_nxt      = op_e'(cmd.cmd_op);
               w_cnt_nxt     = w_cnt_sat;
               w_data_nxt    = cmd.cmd_data;
               w_rot_nxt     = cmd.cmd_rotate;
               w_aborted_nxt = 1'b0;
               w_state_nxt   = (w_cnt_sat == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            cmd.busy = 1'b1;
            // Abort masks the register controls in the same cycle it arrives.
            if (cmd.abort) begin
               w_aborted_nxt = 1'b1;
               w_state_nxt   = DONE;
            end else begin
               s = r_op;
               case (r_op)
                  OP_SHR:  shift_in_R = r_rot ? q_in[0] : r_data[0];
                  OP_SHL:  shift_in_L = r_rot ? q_in[3] : r_data[0];
                  default: ;
               endcase
               w_cnt_nxt  = r_cnt - CNT_W'(1);
               w_data_nxt = r_data >> 1;
               if (r_cnt == CNT_W'(1)) w_state_nxt = DONE;
            end
         end
         DONE: begin
            cmd.busy    = 1'b1;
            cmd.done    = 1'b1;
            cmd.aborted = r_aborted;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Self-checking bench: sequencer driving a behavioural 4-bit selectable-operation register.
module tb_reg_op_sequencer;
   import reg_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] q;
   logic [1:0] s;
   logic       sh_r, sh_l;

   reg_op_sequencer_if #(.DATA_W(16), .CNT_W(5)) bus ();

   reg_op_sequencer #(.DATA_W(16), .CNT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (bus),
      .q_in       (q),
      .s          (s),
      .shift_in_R (sh_r),
      .shift_in_L (sh_l)
   );

   always #5 clk = ~clk;

   // The register being controlled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= 4'h0;
      else case (s)
         2'd1:    q <= ~q;
         2'd2:    q <= {sh_r, q[3:1]};
         2'd3:    q <= {q[2:0], sh_l};
         default: q <= q;
      endcase
   end

   typedef struct {
      logic [1:0]  op;
      int          cycles;
      logic [15:0] sh;
      logic [3:0]  q;
      bit          ab;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      int          cnt;
      logic [15:0] data;
      bit          rot;
      int          n;
      logic [3:0]  q;
   } vec_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          act_cnt = 0;
   int          viol = 0;
   int          done_cyc = 0;
   int          done_count = 0;
   logic [15:0] sh_rec = '0;
   logic [3:0]  m_q = 4'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input int n, input logic [15:0] data,
                                  input bit rot, input logic [3:0] q0, input bit ab);
      exp_t       e;
      logic [3:0] qq;
      logic       b;
      qq   = q0;
      e.sh = '0;
      for (int i = 0; i < n; i++) begin
         b = 1'b0;
         if (op == 2'd2)      b = rot ? qq[0] : data[i];
         else if (op == 2'd3) b = rot ? qq[3] : data[i];
         e.sh[i] = b;
         case (op)
            2'd1:    qq = ~qq;
            2'd2:    qq = {b, qq[3:1]};
            2'd3:    qq = {qq[2:0], b};
            default: ;
         endcase
      end
      e.op = op; e.cycles = n; e.q = qq; e.ab = ab;
      return e;
   endfunction

   // Monitor: collects per-run shift bits and checks each done against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.done) begin
            done_cyc = cyc;
            done_count++;
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               mon_e = sb.pop_front();
               chk("run_cycles", act_cnt, mon_e.cycles);
               chk("shift_bits", int'(sh_rec), int'(mon_e.sh));
               chk("q_final", int'(q), int'(mon_e.q));
               chk("aborted", int'(bus.aborted), int'(mon_e.ab));
            end
            act_cnt = 0;
            sh_rec  = '0;
         end else if (bus.busy) begin
            if (bus.abort) begin
               if (s != 2'd0 || sh_r || sh_l) viol++;
            end else if (sb.size() > 0) begin
               if (s != sb[0].op) viol++;
               if ((sb[0].op != 2'd2 && sh_r) || (sb[0].op != 2'd3 && sh_l)) viol++;
               if (act_cnt < 16) sh_rec[act_cnt] = sh_r | sh_l;
               act_cnt++;
            end
         end else begin
            if (s != 2'd0 || sh_r || sh_l) viol++;
         end
      end
   end

   task automatic send(input logic [1:0] op, input int cnt, input logic [15:0] data, input bit rot,
                       input int n_eff, input bit ab, input bit keep_valid, output int acc);
      bit got;
      exp_t e;
      got = 1'b0;
      @(negedge clk);
      bus.cmd_op     = op;
      bus.cmd_count  = 5'(cnt);
      bus.cmd_data   = data;
      bus.cmd_rotate = rot;
      bus.cmd_valid  = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         #1;
         if (bus.cmd_ready) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         chk("accept_timeout", 0, 1);
         bus.cmd_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      e = model(op, n_eff, data, rot, m_q, ab);
      m_q = e.q;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!keep_valid) bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 200 && !idle; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && !bus.busy) idle = 1'b1;
      end
      if (!idle) begin
         chk("idle_timeout", 0, 1);
         sb.delete();
      end
   endtask

   vec_t tbl[9];
   int   acc, acc2, d1, dc0;

   initial begin
      tbl[0] = '{2'd3, 4,  16'h000B, 1'b0, 4,  4'hD};
      tbl[1] = '{2'd2, 1,  16'h0000, 1'b1, 1,  4'hE};
      tbl[2] = '{2'd3, 2,  16'h0000, 1'b1, 2,  4'hB};
      tbl[3] = '{2'd3, 4,  16'h0000, 1'b0, 4,  4'h0};
      tbl[4] = '{2'd1, 3,  16'h0000, 1'b0, 3,  4'hF};
      tbl[5] = '{2'd0, 0,  16'h0000, 1'b0, 0,  4'hF};
      tbl[6] = '{2'd2, 20, 16'hA5C3, 1'b0, 16, 4'hA};
      tbl[7] = '{2'd0, 5,  16'hFFFF, 1'b0, 5,  4'hA};
      tbl[8] = '{2'd3, 16, 16'h8001, 1'b0, 16, 4'h1};

      reset = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_count = '0;
      bus.cmd_data = '0; bus.cmd_rotate = 1'b0; bus.abort = 1'b0;
      #12;
      chk("rst_ready", int'(bus.cmd_ready), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_s", int'(s), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) begin
         send(tbl[i].op, tbl[i].cnt, tbl[i].data, tbl[i].rot, tbl[i].n, 1'b0, 1'b0, acc);
         wait_idle();
         chk("tbl_q", int'(q), int'(tbl[i].q));
         chk("done_latency", done_cyc - acc, tbl[i].n + 1);
      end

      // Back-to-back with cmd_valid held high.
      send(2'd1, 2, 16'h0000, 1'b0, 2, 1'b0, 1'b1, acc);
      send(2'd2, 3, 16'h0005, 1'b0, 3, 1'b0, 1'b1, acc2);
      d1 = done_cyc;
      chk("b2b_accept", acc2 - d1, 1);
      bus.cmd_valid = 1'b0;
      wait_idle();
      chk("b2b_latency", done_cyc - acc2, 4);

      // Abort in the third RUN cycle.
      send(2'd2, 8, 16'h0003, 1'b0, 2, 1'b1, 1'b0, acc);
      @(posedge clk);
      @(posedge clk);
      #1 bus.abort = 1'b1;
      #1;
      chk("abort_s", int'(s), 0);
      chk("abort_shr", int'(sh_r), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("abort_idle_ready", int'(bus.cmd_ready), 0);
      chk("abort_idle_busy", int'(bus.busy), 0);
      bus.abort = 1'b0;
      #1;
      chk("abort_release_ready", int'(bus.cmd_ready), 1);
      wait_idle();

      // Asynchronous reset between edges in the middle of a run.
      send(2'd3, 10, 16'h03FF, 1'b0, 10, 1'b0, 1'b0, acc);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_s", int'(s), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_ready", int'(bus.cmd_ready), 0);
      sb.delete();
      act_cnt = 0;
      sh_rec  = '0;
      m_q     = 4'h0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      dc0 = done_count;
      repeat (5) @(negedge clk);
      #1;
      chk("arst_no_done", done_count - dc0, 0);
      send(2'd3, 4, 16'h000B, 1'b0, 4, 1'b0, 1'b0, acc);
      wait_idle();
      chk("arst_rerun_q", int'(q), 13);

      chk("idle_violations", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Command-driven controller for the 4-bit selectable-operation register (hold / complement / shift right / shift left).
- Accepts one command per valid/ready handshake and drives the register's mode select s[1:0] for exactly cmd_count clock cycles.
- Feeds serial data or rotate feedback into shift_in_R / shift_in_L, then pulses done.
- Sits between a host/test controller and the register instance.

Parameters:
- DATA_W, 16, width of serial shift-in data buffer; maximum run length.
- CNT_W, 5, width of cmd_count; must satisfy 2**CNT_W > DATA_W.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  0 hold, 1 complement, 2 shift right, 3 shift left (same encoding as register s)
- cmd_count  in  CNT_W  number of register operation cycles
- cmd_data  in  DATA_W  serial shift-in bits, bit 0 first
- cmd_rotate  in  1  1 = shift-in bit taken from q_in (rotate) instead of cmd_data
- abort  in  1  terminate current run
- q_in  in  4  current register output q
- s  out  2  register mode select
- shift_in_R  out  1  register serial input for shift right (enters bit 3)
- shift_in_L  out  1  register serial input for shift left (enters bit 0)
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done: run was cut short

Behaviour:
- Reset is asynchronous and active-high; all flops clear immediately on assertion.
- Reset values: state IDLE, s=00, shift_in_R=0, shift_in_L=0, busy=0, done=0, aborted=0. cmd_ready=0 while reset is high.
- States:
  - IDLE: cmd_ready = !abort; s=00.
    - Handshake when cmd_valid && cmd_ready: latch op, count (saturated to DATA_W if larger), data, rotate.
    - If latched count==0, go to DONE; else go to RUN.
  - RUN: s = latched op every cycle; the remaining count decrements each cycle.
    - Serial input, data mode: the active shift input = data[0]; data shifts right by 1 each cycle.
    - Serial input, rotate mode: op 2 drives shift_in_R = q_in[0]; op 3 drives shift_in_L = q_in[3] (combinational from q_in).
    - Only the shift input matching the op is driven; the other is 0. Both are 0 for ops 0 and 1.
    - When remaining==1, go to DONE next cycle.
    - If abort=1 in RUN: s forced to 00 and shift inputs forced to 0 that same cycle (combinational); next state DONE with aborted set.
  - DONE: s=00, cmd_ready=0, done=1 for exactly one cycle; aborted valid alongside; then IDLE.
- Latency: register sees exactly count consecutive cycles of s=op, starting the cycle after acceptance. done is asserted count+1 cycles after the accept edge.
- Throughput: count+2 cycles per command; count==0 gives 2 cycles.
- Command inputs are ignored outside IDLE. cmd_valid may stay high; the next command is accepted in the first IDLE cycle.
- abort is ignored in DONE; in IDLE it only blocks acceptance.
- Reset mid-run: returns to IDLE immediately with s=00; no done pulse.

Decomposition:
- Shared package reg_ctrl_pkg:
  - op encodings OP_HOLD=0, OP_CPL=1, OP_SHR=2, OP_SHL=3 (shared with register s decoding)
  - state enum IDLE/RUN/DONE
- No sub-module required. The counter and data shifter stay inline in one FSM module.

Test Plan:
- Reset to register q=0000; cmd op=3, count=4, data=0x000B, rotate=0 -> shift_in_L sequence 1,1,0,1; s=11 for 4 cycles; q=1101; done pulses once, aborted=0.
- From q=1101, cmd op=2, count=1, rotate=1 -> shift_in_R=1, q=1110; then op=3, count=2, rotate=1 -> q=1011.
- From q=0000, op=1, count=3 -> s=01 for 3 cycles, q=1111. Then count=0 -> s never leaves 00, done 1 cycle after accept.
- Abort: op=2, count=8, abort asserted in 3rd RUN cycle -> s=00 that cycle, only 2 shifts applied, done=1 with aborted=1; cmd_ready low while abort held in IDLE.
- Back-to-back: cmd_valid held high with two commands (count=2, count=3) -> second accepted the cycle after done; no s glitch between runs; count=20 saturates to 16 cycles.
- Async reset asserted mid-RUN between clock edges -> s=00, busy=0 immediately; no done; next command after release runs normally.
